mem_ctrl: RTL and testbench

- Memory-side stage directly downstream of the CPU sequencer.
- Holds the MAR and MDR, contains the word-addressed RAM array, and executes the CS/R_NW read and write strobes issued by the sequencer.
- Returns MDR contents to the system bus.
- Adds optional wait-state timing with a ready handshake. With zero wait states its timing matches the sequencer's single-cycle memory assumption exactly.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/mem_ctrl_if.sv | 22 ++
 rtl/mem_ctrl_ram.sv | 18 +
 rtl/mem_ctrl.sv | 105 ++++++++++
 tb/tb_mem_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-side stage of the CPU.
// MMIO_ADDR is the top word, which becomes the output register when MEM_CTRL_MMIO_OUT_EN is defined.
package cpu_pkg;
   localparam int WORD_W = 8;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] MMIO_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/mem_ctrl_if.sv
// Sequencer <-> memory stage bundle: register load strobes, access strobes and the returned bus values.
interface mem_ctrl_if #(
   parameter int WORD_W = cpu_pkg::WORD_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
);
   logic [WORD_W-1:0] sysbus;
   logic              load_MAR;
   logic              load_MDR;
   logic              MDR_bus;
   logic              CS;
   logic              R_NW;
   logic [WORD_W-1:0] mdr_drive;
   logic [WORD_W-1:0] mdr_q;
   logic [ADDR_W-1:0] mar_q;
   logic              mem_ready;
   logic [WORD_W-1:0] out_port;

   modport master (output sysbus, load_MAR, load_MDR, MDR_bus, CS, R_NW,
                   input  mdr_drive, mdr_q, mar_q, mem_ready, out_port);
   modport slave  (input  sysbus, load_MAR, load_MDR, MDR_bus, CS, R_NW,
                   output mdr_drive, mdr_q, mar_q, mem_ready, out_port);
endinterface

// File: rtl/mem_ctrl_ram.sv
// Word-addressed single-port RAM with a registered read port; contents are never reset.
module mem_ctrl_ram #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_ctrl.sv
// Memory stage: MAR/MDR, wait-state FSM and RAM. Optional macro MEM_CTRL_MMIO_OUT_EN maps the
// top address to out_port instead of RAM.
module mem_ctrl
   import cpu_pkg::*;
#(
   parameter int WORD_W      = cpu_pkg::WORD_W,
   parameter int ADDR_W      = cpu_pkg::ADDR_W,
   parameter int WAIT_STATES = 0
) (
   input logic        clock,
   input logic        n_reset,
   mem_ctrl_if.slave  bus
);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   mem_state_t        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] mar, acc_addr, addr;
   logic              acc_rnw, rnw;
   logic [WORD_W-1:0] mdr_r, mdr_eff, rdata;
   logic              rd_sel;
   logic              done, rd_done, wr_done, mmio_hit;

   // Completion with zero wait states happens straight out of IDLE; otherwise only in DONE,
   // which replays the address/direction captured when the access started.
   assign done    = n_reset && ((state == IDLE && bus.CS && WAIT_STATES == 0) || state == DONE);
   assign addr    = (state == DONE) ? acc_addr : mar;
   assign rnw     = (state == DONE) ? acc_rnw  : bus.R_NW;
   assign rd_done = done && rnw;
   assign wr_done = done && !rnw;

   // RAM read data lands in rdata one edge after completion; rd_sel exposes it as the MDR
   // for that cycle and the next edge folds it into mdr_r.
   assign mdr_eff = rd_sel ? rdata : mdr_r;

`ifdef MEM_CTRL_MMIO_OUT_EN
   logic [WORD_W-1:0] out_r;
   assign mmio_hit     = (addr == ADDR_W'(MMIO_ADDR));
   assign bus.out_port = out_r;
`else
   assign mmio_hit     = 1'b0;
   assign bus.out_port = '0;
`endif

   mem_ctrl_ram #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_ram (
      .clock (clock),
      .we    (wr_done && !mmio_hit),
      .addr  (addr),
      .wdata (mdr_eff),
      .rdata (rdata)
   );

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mar      <= '0;
         mdr_r    <= '0;
         rd_sel   <= 1'b0;
         acc_addr <= '0;
         acc_rnw  <= 1'b0;
`ifdef MEM_CTRL_MMIO_OUT_EN
         out_r    <= '0;
`endif
      end else begin
         if (bus.load_MAR) mar <= bus.sysbus[ADDR_W-1:0];

         rd_sel <= rd_done && !mmio_hit;
         if (rd_done) begin
`ifdef MEM_CTRL_MMIO_OUT_EN
            if (mmio_hit) mdr_r <= out_r;
`endif
         end else if (bus.load_MDR) begin
            mdr_r <= bus.sysbus;
         end else if (rd_sel) begin
            mdr_r <= rdata;
         end

`ifdef MEM_CTRL_MMIO_OUT_EN
         if (wr_done && mmio_hit) out_r <= mdr_eff;
`endif

         case (state)
            IDLE: if (bus.CS && WAIT_STATES != 0) begin
               cnt      <= CNT_INIT;
               acc_addr <= mar;
               acc_rnw  <= bus.R_NW;
               state    <= WAIT;
            end
            WAIT: begin
               if (!bus.CS)        state <= IDLE;
               else if (cnt == '0) state <= DONE;
               else                cnt   <= cnt - 4'd1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_ready = done;
   assign bus.mdr_q     = mdr_eff;
   assign bus.mar_q     = mar;
   assign bus.mdr_drive = bus.MDR_bus ? mdr_eff : '0;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances with 0, 3 and 2 wait states share clock and reset.
module tb_mem_ctrl;
   logic clock, n_reset;
   int   n_chk, n_pass;

   mem_ctrl_if b0 ();
   mem_ctrl_if b3 ();
   mem_ctrl_if b2 ();

   mem_ctrl #(.WAIT_STATES(0)) u0 (.clock(clock), .n_reset(n_reset), .bus(b0));
   mem_ctrl #(.WAIT_STATES(3)) u3 (.clock(clock), .n_reset(n_reset), .bus(b3));
   mem_ctrl #(.WAIT_STATES(2)) u2 (.clock(clock), .n_reset(n_reset), .bus(b2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr0(input logic [7:0] a, input logic [7:0] d);
      b0.sysbus = a; b0.load_MAR = 1'b1; cyc();
      b0.load_MAR = 1'b0; b0.sysbus = d; b0.load_MDR = 1'b1; cyc();
      b0.load_MDR = 1'b0; b0.CS = 1'b1; b0.R_NW = 1'b0; cyc();
      b0.CS = 1'b0;
   endtask

   task automatic rd0(input logic [7:0] a);
      b0.sysbus = a; b0.load_MAR = 1'b1; cyc();
      b0.load_MAR = 1'b0; b0.CS = 1'b1; b0.R_NW = 1'b1; cyc();
      b0.CS = 1'b0;
   endtask

   // Hold CS until mem_ready, then let the completing edge pass.
   task automatic acc3(input logic rnw, input string tag);
      bit ok = 0;
      b3.CS = 1'b1; b3.R_NW = rnw; #1;
      for (int i = 0; i < 12; i++) begin
         if (b3.mem_ready) begin ok = 1; break; end
         cyc();
      end
      chk(tag, 32'(ok), 1);
      cyc(); b3.CS = 1'b0;
   endtask

   task automatic acc2(input logic rnw, input string tag);
      bit ok = 0;
      b2.CS = 1'b1; b2.R_NW = rnw; #1;
      for (int i = 0; i < 12; i++) begin
         if (b2.mem_ready) begin ok = 1; break; end
         cyc();
      end
      chk(tag, 32'(ok), 1);
      cyc(); b2.CS = 1'b0;
   endtask

   task automatic load3(input logic [7:0] a, input logic [7:0] d);
      b3.sysbus = a; b3.load_MAR = 1'b1; cyc();
      b3.load_MAR = 1'b0; b3.sysbus = d; b3.load_MDR = 1'b1; cyc();
      b3.load_MDR = 1'b0;
   endtask

   task automatic load2(input logic [7:0] a, input logic [7:0] d);
      b2.sysbus = a; b2.load_MAR = 1'b1; cyc();
      b2.load_MAR = 1'b0; b2.sysbus = d; b2.load_MDR = 1'b1; cyc();
      b2.load_MDR = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_out;
      bit rose;
      int lat;
      n_chk = 0; n_pass = 0;
      {b0.sysbus, b0.load_MAR, b0.load_MDR, b0.MDR_bus, b0.CS, b0.R_NW} = '0;
      {b3.sysbus, b3.load_MAR, b3.load_MDR, b3.MDR_bus, b3.CS, b3.R_NW} = '0;
      {b2.sysbus, b2.load_MAR, b2.load_MDR, b2.MDR_bus, b2.CS, b2.R_NW} = '0;
      n_reset = 1'b0;
      cyc();
      b0.CS = 1'b1; #1;
      chk("ready_in_reset", 32'(b0.mem_ready), 0);
      b0.CS = 1'b0;
      cyc();
      n_reset = 1'b1;
      cyc();

      // Reset state
      chk("rst_mar", 32'(b0.mar_q), 0);
      chk("rst_mdr", 32'(b0.mdr_q), 0);
      chk("rst_ready", 32'(b0.mem_ready), 0);
      chk("rst_drive", 32'(b0.mdr_drive), 0);
      b0.MDR_bus = 1'b1; #1;
      chk("rst_drive_en", 32'(b0.mdr_drive), 0);
      b0.MDR_bus = 1'b0;

      // Zero wait states: write 5C to 0A, read back
      b0.sysbus = 8'h2A; b0.load_MAR = 1'b1; cyc();
      b0.load_MAR = 1'b0;
      chk("mar_2a", 32'(b0.mar_q), 32'h0A);
      b0.sysbus = 8'h5C; b0.load_MDR = 1'b1; cyc();
      b0.load_MDR = 1'b0;
      chk("mdr_5c", 32'(b0.mdr_q), 32'h5C);
      b0.CS = 1'b1; b0.R_NW = 1'b0; #1;
      chk("wr_ready", 32'(b0.mem_ready), 1);
      cyc(); b0.CS = 1'b0;
      b0.sysbus = 8'h00; b0.load_MDR = 1'b1; cyc();
      b0.load_MDR = 1'b0;
      chk("mdr_clr", 32'(b0.mdr_q), 0);
      b0.CS = 1'b1; b0.R_NW = 1'b1; #1;
      chk("rd_ready", 32'(b0.mem_ready), 1);
      cyc(); b0.CS = 1'b0;
      chk("rd_5c", 32'(b0.mdr_q), 32'h5C);
      b0.MDR_bus = 1'b1; #1;
      chk("drive_5c", 32'(b0.mdr_drive), 32'h5C);
      b0.MDR_bus = 1'b0;

      // Read completion beats a same-edge load_MDR
      b0.sysbus = 8'h77; b0.load_MDR = 1'b1; b0.CS = 1'b1; b0.R_NW = 1'b1; cyc();
      b0.load_MDR = 1'b0; b0.CS = 1'b0;
      chk("rd_wins", 32'(b0.mdr_q), 32'h5C);
      cyc();
      chk("rd_wins_hold", 32'(b0.mdr_q), 32'h5C);

      // Top address: MMIO register when enabled, plain RAM otherwise
`ifdef MEM_CTRL_MMIO_OUT_EN
      exp_out = 8'hA5;
`else
      exp_out = 8'h00;
`endif
      wr0(8'hFF, 8'hA5);
      chk("mar_top", 32'(b0.mar_q), 32'h1F);
      chk("out_port", 32'(b0.out_port), 32'(exp_out));
      b0.sysbus = 8'h00; b0.load_MDR = 1'b1; cyc(); b0.load_MDR = 1'b0;
      rd0(8'hFF);
      chk("rd_top", 32'(b0.mdr_q), 32'hA5);
      rd0(8'h0A);
      chk("rd_0a_after_top", 32'(b0.mdr_q), 32'h5C);

      // Three wait states: write 3C to 4 with R_NW toggled mid-access
      load3(8'h04, 8'h3C);
      b3.CS = 1'b1; b3.R_NW = 1'b0; cyc();
      b3.R_NW = 1'b1;
      acc3(1'b1, "ws3_wr_done");
      b3.sysbus = 8'h00; b3.load_MDR = 1'b1; cyc(); b3.load_MDR = 1'b0;

      // Read: ready low in IDLE and three WAIT cycles, high in DONE; MAR reload mid-access
      b3.CS = 1'b1; b3.R_NW = 1'b1; #1;
      chk("ws3_c0", 32'(b3.mem_ready), 0);
      cyc();
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("ws3_wait%0d", k), 32'(b3.mem_ready), 0);
         if (k == 1) begin b3.sysbus = 8'h07; b3.load_MAR = 1'b1; end
         cyc();
         b3.load_MAR = 1'b0;
      end
      chk("ws3_done", 32'(b3.mem_ready), 1);
      chk("ws3_mdr_pre", 32'(b3.mdr_q), 0);
      cyc(); b3.CS = 1'b0;
      chk("ws3_mdr", 32'(b3.mdr_q), 32'h3C);
      chk("ws3_mar", 32'(b3.mar_q), 32'h07);

      // Abort: CS dropped in second WAIT cycle
      b3.sysbus = 8'h04; b3.load_MAR = 1'b1; cyc(); b3.load_MAR = 1'b0;
      b3.sysbus = 8'h99; b3.load_MDR = 1'b1; cyc(); b3.load_MDR = 1'b0;
      rose = 0;
      b3.CS = 1'b1; b3.R_NW = 1'b1; cyc();
      rose |= b3.mem_ready; cyc();
      b3.CS = 1'b0; #1;
      for (int k = 0; k < 6; k++) begin rose |= b3.mem_ready; cyc(); end
      chk("abort_ready", 32'(rose), 0);
      chk("abort_mdr", 32'(b3.mdr_q), 32'h99);
      lat = -1;
      b3.CS = 1'b1; b3.R_NW = 1'b1; #1;
      for (int k = 0; k < 10; k++) begin
         if (b3.mem_ready) begin lat = k; break; end
         cyc();
      end
      chk("abort_relat", 32'(lat), 4);
      cyc(); b3.CS = 1'b0;
      chk("abort_reread", 32'(b3.mdr_q), 32'h3C);

      // Two wait states: reset pulse aborts a write in flight
      load2(8'h03, 8'h11);
      acc2(1'b0, "ws2_wr11");
      load2(8'h03, 8'hFF);
      b2.CS = 1'b1; b2.R_NW = 1'b0; cyc();
      cyc();
      n_reset = 1'b0; #1;
      chk("ws2_rst_ready", 32'(b2.mem_ready), 0);
      cyc(); cyc();
      b2.CS = 1'b0; n_reset = 1'b1;
      cyc();
      chk("ws2_rst_mar", 32'(b2.mar_q), 0);
      chk("ws2_rst_mdr", 32'(b2.mdr_q), 0);
      b2.sysbus = 8'h03; b2.load_MAR = 1'b1; cyc(); b2.load_MAR = 1'b0;
      acc2(1'b1, "ws2_rd");
      chk("ws2_ram3", 32'(b2.mdr_q), 32'h11);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
